// File: rtl/pc_controller_if.sv
// pc_controller_if: fetch handshake, instruction fields and datapath strobes between controller and datapath.
interface pc_controller_if;
  logic        imem_req;
  logic        imem_ready;
  logic [5:0]  opcode;
  logic        zero;
  logic [31:0] imm_ext;
  logic [25:0] jump_target;
  logic [31:0] current_pc;
  logic        pc_write;
  logic [31:0] next_pc;
  logic        ir_write;
  logic        alu_go;
  logic        mem_go;
  logic        rf_write;
  modport master (
    input  imem_ready, opcode, zero, imm_ext, jump_target, current_pc,
    output imem_req, pc_write, next_pc, ir_write, alu_go, mem_go, rf_write
  );
  modport slave (
    output imem_ready, opcode, zero, imm_ext, jump_target, current_pc,
    input  imem_req, pc_write, next_pc, ir_write, alu_go, mem_go, rf_write
  );
endinterface

// File: rtl/pc_controller.sv
// pc_controller: multi-cycle fetch/decode/execute sequencer with next-PC selection and retire counting.
module pc_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  pc_controller_if.master        bus,
  output logic [2:0]             state,
  output logic [31:0]            instr_count,
  output logic                   halted,
  output logic                   fault
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT} state_t;
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02, OP_HALT = 6'h3F;
  state_t      st;
  logic [7:0]  wait_cnt;
  logic [31:0] pc4;
  logic        is_r, is_lw, is_sw, is_beq, is_j, is_halt, to_exec, timeout;
  assign is_r    = bus.opcode == OP_R;
  assign is_lw   = bus.opcode == OP_LW;
  assign is_sw   = bus.opcode == OP_SW;
  assign is_beq  = bus.opcode == OP_BEQ;
  assign is_j    = bus.opcode == OP_J;
  assign is_halt = bus.opcode == OP_HALT;
  assign to_exec = is_r | is_lw | is_sw | is_beq;
  assign timeout = wait_cnt == 8'(MEM_TIMEOUT - 1);
  assign pc4 = bus.current_pc + 32'd4;
  assign bus.next_pc = is_j ? {pc4[31:28], bus.jump_target, 2'b00}
                     : (is_beq && bus.zero) ? pc4 + (bus.imm_ext << 2) : pc4;
  assign state        = st;
  assign halted       = st == HALT;
  assign bus.imem_req = st == FETCH || st == WAIT_MEM;
  assign bus.ir_write = st == WAIT_MEM && bus.imem_ready;
  assign bus.alu_go   = st == EXECUTE;
  assign bus.mem_go   = st == MEMORY;
  assign bus.rf_write = st == WRITEBACK;
  // Each path back to FETCH is the single retire point of its instruction.
  assign bus.pc_write = (st == DECODE && !is_halt && !to_exec) ||
                        (st == EXECUTE && !(is_r || is_lw || is_sw)) ||
                        (st == MEMORY && !is_lw) || st == WRITEBACK;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st          <= IDLE;
      wait_cnt    <= '0;
      instr_count <= '0;
      fault       <= 1'b0;
    end else begin
      if (bus.pc_write) instr_count <= instr_count + 32'd1;
      case (st)
        IDLE:      st <= start ? FETCH : IDLE;
        FETCH: begin
          wait_cnt <= '0;
          st       <= WAIT_MEM;
        end
        WAIT_MEM:
          if (bus.imem_ready) st <= DECODE;
          else if (timeout) begin
            fault <= 1'b1;
            st    <= HALT;
          end else wait_cnt <= wait_cnt + 8'd1;
        DECODE:
          if (is_halt) st <= HALT;
          else if (to_exec) st <= EXECUTE;
          else begin
            fault <= fault | !is_j;
            st    <= FETCH;
          end
        EXECUTE:   st <= is_r ? WRITEBACK : (is_lw || is_sw) ? MEMORY : FETCH;
        MEMORY:    st <= is_lw ? WRITEBACK : FETCH;
        WRITEBACK: st <= FETCH;
        default:   st <= HALT;
      endcase
    end
endmodule

// File: tb/tb_pc_controller.sv
// tb_pc_controller: scoreboard bench; expected state paths and retire PCs are queued per instruction and popped as the DUT steps.
module tb_pc_controller;
  localparam int TO = 15;
  localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, J = 6'h02, HLT = 6'h3F;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0]  state;
  logic [31:0] instr_count;
  logic        halted, fault;
  pc_controller_if bus();
  pc_controller #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.master),
    .state(state), .instr_count(instr_count), .halted(halted), .fault(fault)
  );
  always #5 clk = ~clk;
  int n_checks = 0, n_errors = 0;
  logic [2:0]  exp_st[$];
  logic [31:0] exp_npc[$];
  logic [31:0] icount;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, " state"}, {29'd0, state}, 32'd0);
    chk({tag, " strobes"}, {26'd0, bus.imem_req, bus.ir_write, bus.alu_go, bus.mem_go, bus.rf_write, bus.pc_write}, 32'd0);
    chk({tag, " count"}, instr_count, 32'd0);
    chk({tag, " halted/fault"}, {30'd0, halted, fault}, 32'd0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    bus.imem_ready = 1'b0;
    #1 chk_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    icount = 0;
    @(negedge clk);
    chk("idle hold", {29'd0, state}, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  // delay<0 means memory never answers; the instruction must end in HALT by timeout.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                           input logic [25:0] jt, input logic z, input int delay, input logic [31:0] npc);
    int pw = 0, wcnt = 0;
    bit retires;
    exp_st.delete();
    exp_npc.delete();
    exp_st.push_back(3'd1);
    if (delay < 0) begin
      for (int i = 0; i < TO; i++) exp_st.push_back(3'd2);
      exp_st.push_back(3'd7);
    end else begin
      for (int i = 0; i <= delay; i++) exp_st.push_back(3'd2);
      exp_st.push_back(3'd3);
      case (op)
        R:       begin exp_st.push_back(3'd4); exp_st.push_back(3'd6); end
        LW:      begin exp_st.push_back(3'd4); exp_st.push_back(3'd5); exp_st.push_back(3'd6); end
        SW:      begin exp_st.push_back(3'd4); exp_st.push_back(3'd5); end
        BEQ:     exp_st.push_back(3'd4);
        HLT:     exp_st.push_back(3'd7);
        default: ;
      endcase
    end
    retires = delay >= 0 && op != HLT;
    if (retires) exp_npc.push_back(npc);
    bus.opcode = op; bus.current_pc = pc; bus.imm_ext = imm; bus.jump_target = jt; bus.zero = z;
    bus.imem_ready = 1'b0;
    while (exp_st.size() > 0) begin
      logic [2:0] e;
      e = exp_st.pop_front();
      chk({name, " state"}, {29'd0, state}, {29'd0, e});
      if (state == 3'd2) begin
        bus.imem_ready = delay >= 0 && wcnt == delay;
        wcnt++;
      end else bus.imem_ready = 1'b0;
      #1;
      if (bus.pc_write) begin
        pw++;
        if (exp_npc.size() > 0) chk({name, " next_pc"}, bus.next_pc, exp_npc.pop_front());
        else chk({name, " spurious pc_write"}, 32'd1, 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.imem_ready = 1'b0;
    chk({name, " pc_write cycles"}, pw, retires ? 32'd1 : 32'd0);
    if (retires) icount++;
    chk({name, " instr_count"}, instr_count, icount);
    chk({name, " end state"}, {29'd0, state}, retires ? 32'd1 : 32'd7);
  endtask
  initial begin
    bus.imem_ready = 1'b0; bus.opcode = '0; bus.zero = 1'b0; bus.imm_ext = '0;
    bus.jump_target = '0; bus.current_pc = '0;
    do_reset();
    run_instr("rtype", R, 32'h100, 32'h0, 26'h0, 1'b0, 0, 32'h104);
    run_instr("beq_back", BEQ, 32'h200, 32'hFFFF_FFFF, 26'h0, 1'b1, 0, 32'h200);
    run_instr("jump", J, 32'h8000_0000, 32'h0, 26'h40, 1'b0, 1, 32'h8000_0100);
    run_instr("beq_nt", BEQ, 32'h300, 32'h8, 26'h0, 1'b0, 0, 32'h304);
    run_instr("beq_fwd", BEQ, 32'h300, 32'h4, 26'h0, 1'b1, 3, 32'h314);
    run_instr("sw_wrap", SW, 32'hFFFF_FFFC, 32'h0, 26'h0, 1'b0, 0, 32'h0);
    run_instr("lw", LW, 32'h40, 32'h10, 26'h0, 1'b1, 2, 32'h44);
    chk("no fault yet", {31'd0, fault}, 32'd0);
    run_instr("illegal", 6'h3A, 32'h10, 32'h0, 26'h0, 1'b0, 0, 32'h14);
    chk("illegal fault", {31'd0, fault}, 32'd1);
    run_instr("halt_op", HLT, 32'h18, 32'h0, 26'h0, 1'b0, 0, 32'h0);
    chk("halt halted", {31'd0, halted}, 32'd1);
    chk("fault sticky", {31'd0, fault}, 32'd1);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("halt ignores start", {29'd0, state}, 32'd7);
    // Abort an lw in MEMORY with an asynchronous reset after one retired instruction.
    do_reset();
    run_instr("pre_abort", R, 32'h0, 32'h0, 26'h0, 1'b0, 0, 32'h4);
    bus.opcode = LW;
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 10 && state != 3'd5; i++) @(negedge clk);
    bus.imem_ready = 1'b0;
    chk("reach MEMORY", {29'd0, state}, 32'd5);
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("async abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset idle", {29'd0, state}, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    icount = 0;
    run_instr("timeout", R, 32'h20, 32'h0, 26'h0, 1'b0, -1, 32'h0);
    chk("timeout fault", {31'd0, fault}, 32'd1);
    chk("timeout halted", {31'd0, halted}, 32'd1);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("timeout ignores start", {29'd0, state}, 32'd7);
    chk("timeout count", instr_count, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
